// File: rtl/lfo_mod_delay.sv
// Chorus/vibrato delay line: circular sample buffer read back at an LFO-modulated
// fractional delay, resolved by linear interpolation between two adjacent taps.
module lfo_mod_delay #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 10,
    parameter int LFO_W      = 14,
    parameter int BASE_DELAY = 441
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] sample_i,
    input  logic              sampleValid_i,
    input  logic [LFO_W-1:0]  lfoWave_i,
    input  logic              lfoValid_i,
    input  logic [3:0]        depth_i,
    output logic [DATA_W-1:0] sample_o,
    output logic              sampleValid_o,
    output logic              overrun_o
);

    localparam int D_W = ADDR_W + 10;
    localparam int I_W = D_W - 8;
    localparam int P_W = LFO_W + 5;
    localparam int M_W = DATA_W + 10;

    typedef enum logic [2:0] {IDLE, ADDR, RD0, RD1, CALC, OUT} state_t;

    state_t                   state;
    logic [ADDR_W-1:0]        wr_ptr;
    logic [ADDR_W-1:0]        fill_cnt;
    logic [ADDR_W-1:0]        a0_q;
    logic [ADDR_W-1:0]        a1_q;
    logic signed [LFO_W-1:0]  lfo_q;
    logic [3:0]               depth_q;
    logic [7:0]               frac_q;
    logic                     prefill_q;
    logic signed [DATA_W-1:0] s0_q;
    logic signed [DATA_W-1:0] s1_q;

    logic [DATA_W-1:0]        mem [2**ADDR_W];
    logic [DATA_W-1:0]        rd_data;
    logic                     ram_we;
    logic [ADDR_W-1:0]        ram_addr;

    logic signed [P_W-1:0]    mod_prod;
    logic signed [P_W-1:0]    mod_off;
    logic signed [D_W-1:0]    delay_q8;
    logic [I_W-1:0]           delay_int;
    logic [I_W:0]             need;
    logic [ADDR_W-1:0]        addr0;

    logic signed [DATA_W:0]   diff;
    logic signed [M_W-1:0]    ip_prod;
    logic signed [DATA_W-1:0] ip_step;
    logic [DATA_W-1:0]        interp;

    // Modulation offset in Q.8 samples; depth is treated as unsigned
    assign mod_prod  = P_W'(lfo_q) * P_W'($signed({1'b0, depth_q}));
    assign mod_off   = mod_prod >>> 2;
    assign delay_q8  = D_W'(BASE_DELAY * 256) + D_W'(mod_off);
    assign delay_int = delay_q8[D_W-1:8];
    assign need      = (I_W+1)'(delay_int) + (I_W+1)'(1);
    assign addr0     = wr_ptr - delay_int[ADDR_W-1:0];

    assign diff    = (DATA_W+1)'(s1_q) - (DATA_W+1)'(s0_q);
    assign ip_prod = M_W'(diff) * M_W'($signed({1'b0, frac_q}));
    assign ip_step = DATA_W'(ip_prod >>> 8);
    assign interp  = s0_q + ip_step;

    // Single-port RAM: the write slot in IDLE, the two taps in RD0/RD1
    assign ram_we   = (state == IDLE) && sampleValid_i;
    assign ram_addr = (state == RD0) ? a0_q :
                      (state == RD1) ? a1_q : wr_ptr;

    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            mem[ram_addr] <= sample_i;
        end
        rd_data <= mem[ram_addr];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            fill_cnt      <= '0;
            a0_q          <= '0;
            a1_q          <= '0;
            lfo_q         <= '0;
            depth_q       <= '0;
            frac_q        <= '0;
            prefill_q     <= 1'b0;
            s0_q          <= '0;
            s1_q          <= '0;
            sample_o      <= '0;
            sampleValid_o <= 1'b0;
            overrun_o     <= 1'b0;
        end else begin
            sampleValid_o <= 1'b0;
            if (lfoValid_i) begin
                lfo_q <= lfoWave_i;
            end
            if (sampleValid_i && state != IDLE) begin
                overrun_o <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (sampleValid_i) begin
                        depth_q <= depth_i;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    a0_q      <= addr0;
                    a1_q      <= addr0 - ADDR_W'(1);
                    frac_q    <= delay_q8[7:0];
                    // Both taps must already hold written samples
                    prefill_q <= need > (I_W+1)'(fill_cnt);
                    wr_ptr    <= wr_ptr + ADDR_W'(1);
                    if (fill_cnt != '1) begin
                        fill_cnt <= fill_cnt + ADDR_W'(1);
                    end
                    state     <= RD0;
                end
                RD0: begin
                    state <= RD1;
                end
                RD1: begin
                    s0_q  <= rd_data;
                    state <= CALC;
                end
                CALC: begin
                    s1_q  <= rd_data;
                    state <= OUT;
                end
                OUT: begin
                    sample_o      <= prefill_q ? '0 : interp;
                    sampleValid_o <= 1'b1;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfo_mod_delay.sv
// Scoreboard bench for lfo_mod_delay: driver pushes model results,
// monitor pops them on each sampleValid_o pulse.
module tb_lfo_mod_delay;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] sample_i;
    logic        sampleValid_i;
    logic [13:0] lfoWave_i;
    logic        lfoValid_i;
    logic [3:0]  depth_i;
    logic [15:0] sample_o;
    logic        sampleValid_o;
    logic        overrun_o;

    lfo_mod_delay dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .sample_i      (sample_i),
        .sampleValid_i (sampleValid_i),
        .lfoWave_i     (lfoWave_i),
        .lfoValid_i    (lfoValid_i),
        .depth_i       (depth_i),
        .sample_o      (sample_o),
        .sampleValid_o (sampleValid_o),
        .overrun_o     (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   hist[$];
    int   model_lfo = 0;
    int   model_ovr = 0;
    bit   have_acc  = 0;
    int   last_acc  = 0;
    int   checks    = 0;
    int   failures  = 0;
    int   ramp      = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Output for the newest sample in hist, from the delay-line rules
    function automatic int model_out(input int lfo, input int dep);
        int n, off, d, ip, fr, fill, s0, s1;
        n    = hist.size() - 1;
        off  = floor_div(lfo * dep, 4);
        d    = 441 * 256 + off;
        ip   = d / 256;
        fr   = d % 256;
        fill = (n < 1023) ? n : 1023;
        if (ip + 1 > fill) return 0;
        s0 = hist[n - ip];
        s1 = hist[n - ip - 1];
        return s0 + floor_div((s1 - s0) * fr, 256);
    endfunction

    task automatic drive(input int s, input bit lv, input int l, input int d);
        logic signed [15:0] sv;
        exp_t e;
        sv            = 16'(s);
        sample_i      = sv;
        depth_i       = 4'(d);
        lfoValid_i    = lv;
        lfoWave_i     = 14'(l);
        sampleValid_i = 1'b1;
        @(negedge clk_i);
        sampleValid_i = 1'b0;
        lfoValid_i    = 1'b0;
        if (lv) model_lfo = l;
        if (!have_acc || (cyc - last_acc >= 6)) begin
            hist.push_back(int'(sv));
            e.val = model_out(model_lfo, d);
            e.cyc = cyc + 5;
            exp_q.push_back(e);
            have_acc = 1'b1;
            last_acc = cyc;
        end else begin
            model_ovr = 1;
        end
    endtask

    task automatic lfo_pulse(input int l);
        lfoValid_i = 1'b1;
        lfoWave_i  = 14'(l);
        @(negedge clk_i);
        lfoValid_i = 1'b0;
        model_lfo  = l;
    endtask

    task automatic idle(input int g);
        repeat (g) @(negedge clk_i);
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        if (sampleValid_o) begin
            check("out_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sample_o", int'($signed(sample_o)), e.val);
                check("latency", cyc, e.cyc);
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            check("missing_out", int'(sampleValid_o), 1);
            void'(exp_q.pop_front());
        end
    end

    initial begin
        rst_i         = 1'b1;
        sample_i      = '0;
        sampleValid_i = 1'b0;
        lfoWave_i     = '0;
        lfoValid_i    = 1'b0;
        depth_i       = '0;
        repeat (3) @(negedge clk_i);
        check("rst_sample_o", int'(sample_o), 0);
        check("rst_valid_o", int'(sampleValid_o), 0);
        check("rst_overrun_o", int'(overrun_o), 0);
        rst_i = 1'b0;
        idle(2);

        for (int i = 0; i < 500; i++) begin
            drive(ramp * 100, 1'b0, 0, 0);
            ramp++;
            idle($urandom_range(5, 8));
        end

        for (int i = 0; i < 100; i++) begin
            drive(ramp * 100, i == 0, 512, 1);
            ramp++;
            idle(5);
        end

        for (int i = 0; i < 100; i++) begin
            drive(ramp * 100, i == 0, -512, 1);
            ramp++;
            idle(5);
        end

        for (int i = 0; i < 3000; i++) begin
            drive(ramp * 100, i == 0, 8191, 15);
            ramp++;
            idle(5);
        end
        check("overrun_wrap", int'(overrun_o), model_ovr);

        for (int i = 0; i < 400; i++) begin
            drive(int'($urandom_range(0, 65535)) - 32768,
                  $urandom_range(0, 2) == 0,
                  int'($urandom_range(0, 16383)) - 8192,
                  int'($urandom_range(0, 15)));
            if ($urandom_range(0, 7) == 0) begin
                idle($urandom_range(2, 4));
            end else begin
                if ($urandom_range(0, 3) == 0) begin
                    lfo_pulse(int'($urandom_range(0, 16383)) - 8192);
                end
                idle($urandom_range(5, 7));
            end
        end

        idle(8);
        drive(1234, 1'b0, 0, 3);
        idle(2);
        drive(-999, 1'b0, 0, 3);
        check("overrun_collide", int'(overrun_o), model_ovr);
        idle(8);
        drive(4321, 1'b1, 4000, 7);
        idle(5);
        drive(-4321, 1'b1, -7000, 12);
        idle(8);

        drive(5555, 1'b0, 0, 0);
        idle(2);
        rst_i = 1'b1;
        exp_q.delete();
        hist.delete();
        model_lfo = 0;
        model_ovr = 0;
        have_acc  = 1'b0;
        #1;
        check("midrst_sample_o", int'(sample_o), 0);
        check("midrst_valid_o", int'(sampleValid_o), 0);
        check("midrst_overrun_o", int'(overrun_o), 0);
        idle(3);
        rst_i = 1'b0;
        idle(2);

        for (int i = 0; i < 460; i++) begin
            drive(int'($urandom_range(1, 30000)), 1'b0, 0, 0);
            idle(5);
        end

        idle(20);
        check("queue_empty", exp_q.size(), 0);
        check("overrun_end", int'(overrun_o), model_ovr);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
